cnn_weight_loader: RTL and testbench
====================================

Name: cnn_weight_loader

Overview:
- Host-side sequencer that turns a flat byte stream into the CNN's weight-load write transactions.
- It drives the feature, bias and fully-connected weight memory write ports, then issues the convolution start strobe.
- It replaces the bench-driven load sequence and sits between a byte source (UART/DMA bridge) and the CNN top.
- Stream order: 3 features × 16 bytes, then 4 bias bytes, then 432 FC bytes; 484 bytes in total.

Parameters:
DATA_WIDTH, 8, width of one weight byte
NUM_FEATURES, 3, number of kernel feature maps
KERNEL_SIZE, 4, kernel side; a feature word is KERNEL_SIZE*KERNEL_SIZE bytes
FLATTENED_LENGTH, 432, total FC weights
FC_WORDS, 16, FC weights per write transaction

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  one-cycle pulse that begins a load sequence; ignored while busy
in_data  input  DATA_WIDTH  signed weight byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte on a cycle where in_valid&&in_ready
feature_weights_input  output  DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE  packed feature word, element 0 at MSBs
feature_writeAddr  output  2  feature slot 0..NUM_FEATURES-1
feature_WrEn  output  1  active-low feature write strobe
bias_weights_input  output  DATA_WIDTH*(NUM_FEATURES+1)  packed biases, element 0 at MSBs
bias_WrEn  output  1  active-low bias write strobe
fullyconnected_weights_input  output  DATA_WIDTH*FC_WORDS  packed FC word, element 0 at MSBs
fullyconnected_writeAddr  output  5  FC word address 0..26
fullyconnected_WrEn  output  1  active-low FC write strobe
convolution_enable  output  1  active-low start strobe to the CNN
busy  output  1  sequence in progress
done  output  1  sticky; set after the start strobe, cleared by load_start or rst

Behaviour:
- All outputs are registered.
- **Reset values:**
  - in_ready=0, busy=0, done=0.
  - All WrEn and convolution_enable = 1 (inactive).
  - Addresses = 0; all packed data outputs = 0.
  - Internal byte and word counters = 0; state = IDLE.
- **Reset mid-sequence:** abort immediately to the reset values. No partial write is issued. A strobe active in that cycle returns to 1 on the next edge.
- **States:** IDLE, LOAD_FEAT, WR_FEAT, LOAD_BIAS, WR_BIAS, LOAD_FC, WR_FC, START.
- **IDLE:** on load_start go to LOAD_FEAT; clear done; set busy; zero the counters.
- **Assembly (LOAD_* states):**
  - in_ready=1.
  - Each accepted byte shifts into the assembly register: shift left by DATA_WIDTH, new byte in the LSBs.
  - The first byte of a group therefore lands in the MSBs.
- **LOAD_FEAT:** after the 16th accepted byte go to WR_FEAT.
- **WR_FEAT:**
  - Lasts exactly one cycle; in_ready=0.
  - feature_weights_input and feature_writeAddr are valid and stable on the same cycle feature_WrEn=0.
  - Next state is LOAD_FEAT with the address incremented, or LOAD_BIAS after slot NUM_FEATURES-1.
- **LOAD_BIAS / WR_BIAS:** 4 bytes, then one cycle with bias_WrEn=0, then LOAD_FC.
- **LOAD_FC / WR_FC:**
  - 16 bytes, then one cycle with fullyconnected_WrEn=0 at the current address.
  - The address increments after each write.
  - After address 26 (FLATTENED_LENGTH/FC_WORDS-1) go to START.
- **START:** convolution_enable=0 for exactly one cycle. Next edge: busy=0, done=1, state IDLE.
- **Strobe hold:** at most one strobe is low in any cycle. Packed data and address outputs hold their last written values between writes.
- **Stalls:** in_valid low stalls the sequence with no timeout. Bytes offered while in_ready=0 are not consumed and must be held by the source.
- **Latency:** with in_valid held high, the first in_ready=1 is the cycle after load_start is sampled.
  - Byte acceptance takes 484 cycles, plus 31 write cycles.
  - The convolution_enable low cycle follows immediately: cycle 516 counting from the first ready cycle.
  - done rises on cycle 517.
- **load_start while busy:** ignored. load_start in the same cycle as rst: rst wins.

Test Plan:
- **Reset:** rst=1 for 2 cycles with load_start=1 → all WrEn=1, convolution_enable=1, in_ready=0, busy=0, done=0.
- **Feature packing:** stream bytes -53,43,...,26 as feature 0 → exactly one cycle with feature_WrEn=0 and feature_writeAddr=0. In that cycle feature_weights_input[127:120]=8'hCB (-53) and [7:0]=8'h1A (26). Features 1 and 2 follow at addresses 1 and 2.
- **Bias packing:** bias bytes 10,0,0,-8 → single bias_WrEn=0 cycle with bias_weights_input=32'h0A0000F8.
- **Full run, in_valid always high:**
  - 27 fullyconnected_WrEn pulses at addresses 0..26.
  - convolution_enable=0 exactly once, at cycle 516 after the first ready.
  - done=1 on cycle 517 and stays set.
- **Back-pressure:** in_valid toggled randomly, plus a byte offered during a WR cycle → that byte is not consumed until in_ready returns. Written words match the reference model byte-for-byte.
- **Abort:** rst asserted after byte 200 (inside the FC phase) → outputs go to reset values next edge. A following load_start with a fresh 484-byte stream completes normally, with FC addresses restarting at 0.

Source files
------------

// File: rtl/cnn_weight_loader.sv
// Byte-stream weight sequencer for the CNN: assembles feature, bias and FC words
// from an incoming byte stream, writes them with active-low strobes, then fires the convolution start.
module cnn_weight_loader #(
    parameter int DATA_WIDTH       = 8,
    parameter int NUM_FEATURES     = 3,
    parameter int KERNEL_SIZE      = 4,
    parameter int FLATTENED_LENGTH = 432,
    parameter int FC_WORDS         = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load_start,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] feature_weights_input,
    output logic [1:0]                                  feature_writeAddr,
    output logic                                        feature_WrEn,
    output logic [DATA_WIDTH*(NUM_FEATURES+1)-1:0]      bias_weights_input,
    output logic                                        bias_WrEn,
    output logic [DATA_WIDTH*FC_WORDS-1:0]              fullyconnected_weights_input,
    output logic [4:0]                                  fullyconnected_writeAddr,
    output logic                                        fullyconnected_WrEn,
    output logic                                        convolution_enable,
    output logic                                        busy,
    output logic                                        done
);

    localparam int FEAT_BYTES = KERNEL_SIZE * KERNEL_SIZE;
    localparam int BIAS_BYTES = NUM_FEATURES + 1;
    localparam int FEAT_W     = DATA_WIDTH * FEAT_BYTES;
    localparam int BIAS_W     = DATA_WIDTH * BIAS_BYTES;
    localparam int FC_W       = DATA_WIDTH * FC_WORDS;
    localparam int ASM_W_FB   = (FEAT_W > BIAS_W) ? FEAT_W : BIAS_W;
    localparam int ASM_W      = (ASM_W_FB > FC_W) ? ASM_W_FB : FC_W;
    localparam int MAX_BYTES  = ASM_W / DATA_WIDTH;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);
    localparam int FC_LAST    = FLATTENED_LENGTH / FC_WORDS - 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_FEAT, WR_FEAT, LOAD_BIAS, WR_BIAS, LOAD_FC, WR_FC, START
    } state_t;

    state_t                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_byte_cnt, w_byte_cnt_next;
    logic [1:0]              r_feat_addr, w_feat_addr_next;
    logic [4:0]              r_fc_addr, w_fc_addr_next;
    // Only the bytes preceding the incoming one are stored; the newest byte comes straight from in_data.
    logic [ASM_W-DATA_WIDTH-1:0] r_asm, w_asm_next;
    logic [ASM_W-1:0]        w_asm_shift;
    logic                    w_accept;

    logic                    r_in_ready, w_in_ready_next;
    logic                    r_feat_wren, w_feat_wren_next;
    logic                    r_bias_wren, w_bias_wren_next;
    logic                    r_fc_wren, w_fc_wren_next;
    logic                    r_conv_en, w_conv_en_next;
    logic                    r_busy, w_busy_next;
    logic                    r_done, w_done_next;
    logic [FEAT_W-1:0]       r_feat_out, w_feat_out_next;
    logic [1:0]              r_feat_waddr, w_feat_waddr_next;
    logic [BIAS_W-1:0]       r_bias_out, w_bias_out_next;
    logic [FC_W-1:0]         r_fc_out, w_fc_out_next;
    logic [4:0]              r_fc_waddr, w_fc_waddr_next;

    assign w_accept    = in_valid && r_in_ready;
    assign w_asm_shift = {r_asm, in_data};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_next      = r_state;
        w_byte_cnt_next   = r_byte_cnt;
        w_feat_addr_next  = r_feat_addr;
        w_fc_addr_next    = r_fc_addr;
        w_asm_next        = r_asm;
        w_in_ready_next   = 1'b0;
        w_feat_wren_next  = 1'b1;
        w_bias_wren_next  = 1'b1;
        w_fc_wren_next    = 1'b1;
        w_conv_en_next    = 1'b1;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_feat_out_next   = r_feat_out;
        w_feat_waddr_next = r_feat_waddr;
        w_bias_out_next   = r_bias_out;
        w_fc_out_next     = r_fc_out;
        w_fc_waddr_next   = r_fc_waddr;

        unique case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_state_next     = LOAD_FEAT;
                    w_in_ready_next  = 1'b1;
                    w_busy_next      = 1'b1;
                    w_done_next      = 1'b0;
                    w_byte_cnt_next  = '0;
                    w_feat_addr_next = '0;
                    w_fc_addr_next   = '0;
                end
            end
            LOAD_FEAT: begin
                w_in_ready_next = 1'b1;
                if (w_accept) begin
                    w_asm_next = w_asm_shift[ASM_W-DATA_WIDTH-1:0];
                    if (r_byte_cnt == CNT_W'(FEAT_BYTES - 1)) begin
                        w_byte_cnt_next   = '0;
                        w_state_next      = WR_FEAT;
                        w_in_ready_next   = 1'b0;
                        w_feat_wren_next  = 1'b0;
                        w_feat_out_next   = w_asm_shift[FEAT_W-1:0];
                        w_feat_waddr_next = r_feat_addr;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                    end
                end
            end
            WR_FEAT: begin
                w_in_ready_next = 1'b1;
                if (r_feat_addr == 2'(NUM_FEATURES - 1)) begin
                    w_state_next = LOAD_BIAS;
                end else begin
                    w_feat_addr_next = r_feat_addr + 2'd1;
                    w_state_next     = LOAD_FEAT;
                end
            end
            LOAD_BIAS: begin
                w_in_ready_next = 1'b1;
                if (w_accept) begin
                    w_asm_next = w_asm_shift[ASM_W-DATA_WIDTH-1:0];
                    if (r_byte_cnt == CNT_W'(BIAS_BYTES - 1)) begin
                        w_byte_cnt_next  = '0;
                        w_state_next     = WR_BIAS;
                        w_in_ready_next  = 1'b0;
                        w_bias_wren_next = 1'b0;
                        w_bias_out_next  = w_asm_shift[BIAS_W-1:0];
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                    end
                end
            end
            WR_BIAS: begin
                w_in_ready_next = 1'b1;
                w_state_next    = LOAD_FC;
            end
            LOAD_FC: begin
                w_in_ready_next = 1'b1;
                if (w_accept) begin
                    w_asm_next = w_asm_shift[ASM_W-DATA_WIDTH-1:0];
                    if (r_byte_cnt == CNT_W'(FC_WORDS - 1)) begin
                        w_byte_cnt_next = '0;
                        w_state_next    = WR_FC;
                        w_in_ready_next = 1'b0;
                        w_fc_wren_next  = 1'b0;
                        w_fc_out_next   = w_asm_shift[FC_W-1:0];
                        w_fc_waddr_next = r_fc_addr;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                    end
                end
            end
            WR_FC: begin
                if (r_fc_addr == 5'(FC_LAST)) begin
                    w_state_next   = START;
                    w_conv_en_next = 1'b0;
                end else begin
                    w_fc_addr_next  = r_fc_addr + 5'd1;
                    w_state_next    = LOAD_FC;
                    w_in_ready_next = 1'b1;
                end
            end
            START: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
                w_done_next  = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state      <= IDLE;
            r_byte_cnt   <= '0;
            r_feat_addr  <= '0;
            r_fc_addr    <= '0;
            // NOTE: the assembly register is a plain register, not a memory, so clearing it on reset is cheap.
            r_asm        <= '0;
            r_in_ready   <= 1'b0;
            r_feat_wren  <= 1'b1;
            r_bias_wren  <= 1'b1;
            r_fc_wren    <= 1'b1;
            r_conv_en    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_feat_out   <= '0;
            r_feat_waddr <= '0;
            r_bias_out   <= '0;
            r_fc_out     <= '0;
            r_fc_waddr   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_feat_addr  <= w_feat_addr_next;
            r_fc_addr    <= w_fc_addr_next;
            r_asm        <= w_asm_next;
            r_in_ready   <= w_in_ready_next;
            r_feat_wren  <= w_feat_wren_next;
            r_bias_wren  <= w_bias_wren_next;
            r_fc_wren    <= w_fc_wren_next;
            r_conv_en    <= w_conv_en_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_feat_out   <= w_feat_out_next;
            r_feat_waddr <= w_feat_waddr_next;
            r_bias_out   <= w_bias_out_next;
            r_fc_out     <= w_fc_out_next;
            r_fc_waddr   <= w_fc_waddr_next;
        end
    end

    assign in_ready                     = r_in_ready;
    assign feature_weights_input        = r_feat_out;
    assign feature_writeAddr            = r_feat_waddr;
    assign feature_WrEn                 = r_feat_wren;
    assign bias_weights_input           = r_bias_out;
    assign bias_WrEn                    = r_bias_wren;
    assign fullyconnected_weights_input = r_fc_out;
    assign fullyconnected_writeAddr     = r_fc_waddr;
    assign fullyconnected_WrEn          = r_fc_wren;
    assign convolution_enable           = r_conv_en;
    assign busy                         = r_busy;
    assign done                         = r_done;

endmodule

// File: tb/tb_cnn_weight_loader.sv
// Self-checking bench for cnn_weight_loader: random byte streams and valid patterns,
// written words compared against a byte-array reference model of the stream layout.
module tb_cnn_weight_loader;

    localparam int TOTAL  = 484;
    localparam int FEAT_B = 16;
    localparam int BIAS_B = 4;
    localparam int NFEAT  = 3;
    localparam int NFC    = 27;
    localparam int FC_B   = 16;
    localparam int BIAS_BASE = NFEAT * FEAT_B;
    localparam int FC_BASE   = BIAS_BASE + BIAS_B;

    logic         clk = 1'b0;
    logic         rst, load_start, in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [127:0] feature_weights_input;
    logic [1:0]   feature_writeAddr;
    logic         feature_WrEn;
    logic [31:0]  bias_weights_input;
    logic         bias_WrEn;
    logic [127:0] fullyconnected_weights_input;
    logic [4:0]   fullyconnected_writeAddr;
    logic         fullyconnected_WrEn;
    logic         convolution_enable;
    logic         busy, done;

    cnn_weight_loader dut (
        .clk                          (clk),
        .rst                          (rst),
        .load_start                   (load_start),
        .in_data                      (in_data),
        .in_valid                     (in_valid),
        .in_ready                     (in_ready),
        .feature_weights_input        (feature_weights_input),
        .feature_writeAddr            (feature_writeAddr),
        .feature_WrEn                 (feature_WrEn),
        .bias_weights_input           (bias_weights_input),
        .bias_WrEn                    (bias_WrEn),
        .fullyconnected_weights_input (fullyconnected_weights_input),
        .fullyconnected_writeAddr     (fullyconnected_writeAddr),
        .fullyconnected_WrEn          (fullyconnected_WrEn),
        .convolution_enable           (convolution_enable),
        .busy                         (busy),
        .done                         (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]   stream [TOTAL];
    logic [127:0] feat_q[$];
    int           feat_addr_q[$];
    logic [127:0] bias_q[$];
    logic [127:0] fc_q[$];
    int           fc_addr_q[$];
    int           conv_cnt, conv_cyc, done_cyc, multi_low, cyc;
    bit           ready_seen;
    int           idx;

    // Reference: word k of n bytes starting at base, element 0 in the most significant byte.
    function automatic logic [127:0] exp_word(input int base, input int n);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < n; j++) w[8*(n-1-j) +: 8] = stream[base + j];
        return w;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < TOTAL; i++) stream[i] = 8'($urandom);
    endtask

    task automatic clear_record();
        feat_q.delete(); feat_addr_q.delete(); bias_q.delete();
        fc_q.delete(); fc_addr_q.delete();
        conv_cnt = 0; conv_cyc = 0; done_cyc = 0; multi_low = 0;
        cyc = 0; ready_seen = 0;
    endtask

    task automatic sample();
        int nlow;
        nlow = int'(!feature_WrEn) + int'(!bias_WrEn) + int'(!fullyconnected_WrEn)
             + int'(!convolution_enable);
        if (nlow > 1) multi_low++;
        if (ready_seen) cyc++;
        else if (in_ready) begin
            ready_seen = 1;
            cyc = 1;
        end
        if (!feature_WrEn) begin
            feat_q.push_back(feature_weights_input);
            feat_addr_q.push_back(int'(feature_writeAddr));
        end
        if (!bias_WrEn) bias_q.push_back(128'(bias_weights_input));
        if (!fullyconnected_WrEn) begin
            fc_q.push_back(fullyconnected_weights_input);
            fc_addr_q.push_back(int'(fullyconnected_writeAddr));
        end
        if (!convolution_enable) begin
            conv_cnt++;
            conv_cyc = cyc;
        end
        if (done && ready_seen && done_cyc == 0) done_cyc = cyc;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_strobes"},
              128'({feature_WrEn, bias_WrEn, fullyconnected_WrEn, convolution_enable}), 128'(4'hF));
        check({tag, "_addrs"}, 128'({feature_writeAddr, fullyconnected_writeAddr}), 128'(0));
        check({tag, "_data"},
              feature_weights_input | fullyconnected_weights_input | 128'(bias_weights_input), 128'(0));
    endtask

    // Drives one load sequence; returns early after an abort at byte abort_at.
    task automatic run_load(input bit rand_valid, input int abort_at, input int restart_at,
                            output bit finished);
        bit v;
        clear_record();
        idx = 0;
        finished = 0;
        @(negedge clk);
        load_start = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            load_start = 1'b0;
            sample();
            if (c == 0) begin
                check("start_done_cleared", 128'(done), 128'(0));
                check("start_busy", 128'(busy), 128'(1));
                check("start_ready", 128'(in_ready), 128'(1));
            end
            if (done) begin
                finished = 1;
                break;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_reset_values("abort");
                return;
            end
            if (c == restart_at) load_start = 1'b1;
            v = (idx < TOTAL) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_valid = v;
            in_data  = stream[idx < TOTAL ? idx : TOTAL - 1];
            if (v && in_ready) idx++;
        end
        in_valid = 1'b0;
        check("run_finished", 128'(finished), 128'(1));
    endtask

    task automatic verify(input bit timing);
        check("feat_count", 128'(feat_q.size()), 128'(NFEAT));
        for (int i = 0; i < feat_q.size() && i < NFEAT; i++) begin
            check($sformatf("feat_addr%0d", i), 128'(feat_addr_q[i]), 128'(i));
            check($sformatf("feat_data%0d", i), feat_q[i], exp_word(i * FEAT_B, FEAT_B));
        end
        check("bias_count", 128'(bias_q.size()), 128'(1));
        if (bias_q.size() > 0) check("bias_data", bias_q[0], exp_word(BIAS_BASE, BIAS_B));
        check("fc_count", 128'(fc_q.size()), 128'(NFC));
        for (int i = 0; i < fc_q.size() && i < NFC; i++) begin
            check($sformatf("fc_addr%0d", i), 128'(fc_addr_q[i]), 128'(i));
            check($sformatf("fc_data%0d", i), fc_q[i], exp_word(FC_BASE + i * FC_B, FC_B));
        end
        check("conv_pulses", 128'(conv_cnt), 128'(1));
        check("one_strobe_max", 128'(multi_low), 128'(0));
        if (timing) begin
            check("conv_cycle", 128'(conv_cyc), 128'(516));
            check("done_cycle", 128'(done_cyc), 128'(517));
        end
        repeat (3) @(negedge clk);
        check("done_sticky", 128'(done), 128'(1));
        check("busy_clear", 128'(busy), 128'(0));
        check("hold_feat_addr", 128'(feature_writeAddr), 128'(NFEAT - 1));
        check("hold_fc_addr", 128'(fullyconnected_writeAddr), 128'(NFC - 1));
        check("hold_fc_data", fullyconnected_weights_input, exp_word(FC_BASE + (NFC - 1) * FC_B, FC_B));
    endtask

    initial begin
        bit fin;
        logic [127:0] w0;
        rst = 1'b1;
        load_start = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
        check("post_reset_idle_ready", 128'(in_ready), 128'(0));
        check("post_reset_idle_busy", 128'(busy), 128'(0));

        // Full run with in_valid always high and known feature/bias bytes.
        fill_random();
        stream[0]  = 8'hCB;
        stream[15] = 8'h1A;
        stream[BIAS_BASE + 0] = 8'h0A;
        stream[BIAS_BASE + 1] = 8'h00;
        stream[BIAS_BASE + 2] = 8'h00;
        stream[BIAS_BASE + 3] = 8'hF8;
        run_load(1'b0, -1, -1, fin);
        if (feat_q.size() > 0) begin
            w0 = feat_q[0];
            check("feat0_msb", 128'(w0[127:120]), 128'(8'hCB));
            check("feat0_lsb", 128'(w0[7:0]), 128'(8'h1A));
        end
        if (bias_q.size() > 0) check("bias_known", bias_q[0], 128'(32'h0A0000F8));
        verify(1'b1);

        // Back-pressure plus a load_start while busy, which must be ignored.
        fill_random();
        run_load(1'b1, -1, 100, fin);
        verify(1'b0);

        // Abort inside the FC phase, then a fresh complete load.
        fill_random();
        run_load(1'b1, 200, -1, fin);
        @(negedge clk);
        check("abort_stays_idle", 128'(busy), 128'(0));
        fill_random();
        run_load(1'b1, -1, -1, fin);
        verify(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
